// File: rtl/sd_sched_pkg.sv
// Shared types and constants for the SD command scheduler.
// The FSM state encoding, default command settings and direction codes
// live here so the scheduler and its arbiter agree on them.
package sd_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_LO     = 3'd1,
    S_WAIT_LO   = 3'd2,
    S_RD_HI     = 3'd3,
    S_WAIT_HI   = 3'd4,
    S_ISSUE     = 3'd5,
    S_WAIT_DONE = 3'd6
  } sched_state_t;

  // CMD24 single-block write / CMD17 single-block read, 48-bit response,
  // CRC and index checks enabled.
  localparam logic [15:0] CMD24_SET = 16'h181A;
  localparam logic [15:0] CMD17_SET = 16'h111A;

  // dir_o encoding.
  localparam logic DIR_TX = 1'b1;
  localparam logic DIR_RX = 1'b0;

  // Bit positions of each queue in the arbiter request/grant vectors.
  localparam int REQ_TX = 1;
  localparam int REQ_RX = 0;

endpackage

// File: rtl/sd_rr_arb2.sv
// Two-way round-robin arbiter between the TX and RX descriptor queues.
// A lone requester always wins; on a tie the direction opposite to the
// last grant wins. After reset TX wins the first tie.
module sd_rr_arb2
  import sd_sched_pkg::*;
(
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic tx_next;

  // Combinational grant from requests and the round-robin pointer.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b10:   grant = 2'b10;
      2'b01:   grant = 2'b01;
      2'b11:   grant = tx_next ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer remembers the last granted side; it only moves when a grant is taken.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      tx_next <= 1'b1;
    else if (advance)
      tx_next <= grant[REQ_RX];
  end

endmodule

// File: rtl/sd_cmd_scheduler.sv
// SD command scheduler: pops a two-word (32-bit argument) descriptor from
// the TX or RX queue, issues the matching command, and reports the result.
// Optional watchdog: define SD_SCHED_TIMEOUT_EN to abort a command that
// is not accepted/completed within TIMEOUT cycles of entering ISSUE.
module sd_cmd_scheduler
  import sd_sched_pkg::*;
#(
  parameter logic [15:0] CMD_TX_SET = CMD24_SET,
  parameter logic [15:0] CMD_RX_SET = CMD17_SET,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        sched_en_i,
  input  logic        tx_bd_empty_i,
  input  logic        rx_bd_empty_i,
  output logic        re_tx_bd_o,
  output logic        re_rx_bd_o,
  input  logic [15:0] tx_bd_dat_i,
  input  logic [15:0] rx_bd_dat_i,
  output logic        write_req_o,
  output logic [15:0] cmd_set_o,
  output logic [31:0] cmd_arg_o,
  input  logic        we_ack_i,
  input  logic        cmd_done_i,
  input  logic        cmd_err_i,
  output logic        busy_o,
  output logic        dir_o,
  output logic        bd_done_o,
  output logic        bd_err_o
);

  sched_state_t state;
  logic [1:0]   arb_req;
  logic [1:0]   arb_gnt;
  logic         arb_adv;
  logic [15:0]  rd_dat;
  logic         wd_expire;

  assign arb_req[REQ_TX] = ~tx_bd_empty_i;
  assign arb_req[REQ_RX] = ~rx_bd_empty_i;
  // A grant is taken only from IDLE; disabling mid-descriptor just blocks the next one.
  assign arb_adv = (state == S_IDLE) && sched_en_i && (|arb_req);

  sd_rr_arb2 u_arb (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req      (arb_req),
    .advance  (arb_adv),
    .grant    (arb_gnt)
  );

  // Read strobes are a pure state decode so each lasts exactly one cycle.
  assign re_tx_bd_o = ((state == S_RD_LO) || (state == S_RD_HI)) && (dir_o == DIR_TX);
  assign re_rx_bd_o = ((state == S_RD_LO) || (state == S_RD_HI)) && (dir_o == DIR_RX);
  assign rd_dat     = (dir_o == DIR_TX) ? tx_bd_dat_i : rx_bd_dat_i;
  assign busy_o     = (state != S_IDLE);

`ifdef SD_SCHED_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Expiry fires on the edge where the count would reach TIMEOUT.
  assign wd_expire = ((state == S_ISSUE) || (state == S_WAIT_DONE)) &&
                     ((wd_cnt + 16'd1) == TIMEOUT);

  // Watchdog clears as ISSUE is entered and counts through ISSUE and WAIT_DONE.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      wd_cnt <= 16'd0;
    else if (state == S_WAIT_HI)
      wd_cnt <= 16'd0;
    else if ((state == S_ISSUE) || (state == S_WAIT_DONE))
      wd_cnt <= wd_cnt + 16'd1;
  end
`else
  // Without the watchdog TIMEOUT has no effect; ISSUE and WAIT_DONE wait forever.
  logic [15:0] timeout_unused;
  assign timeout_unused = TIMEOUT;
  assign wd_expire      = 1'b0;
`endif

  // Main descriptor sequencer: grant, two word reads, issue, await completion.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      dir_o       <= DIR_RX;
      write_req_o <= 1'b0;
      bd_done_o   <= 1'b0;
      bd_err_o    <= 1'b0;
      cmd_set_o   <= 16'h0000;
      cmd_arg_o   <= 32'h0000_0000;
    end else begin
      bd_done_o <= 1'b0;
      bd_err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_adv) begin
            dir_o <= arb_gnt[REQ_TX] ? DIR_TX : DIR_RX;
            state <= S_RD_LO;
          end
        end
        S_RD_LO:   state <= S_WAIT_LO;
        S_WAIT_LO: begin
          cmd_arg_o[15:0] <= rd_dat;
          state           <= S_RD_HI;
        end
        S_RD_HI:   state <= S_WAIT_HI;
        S_WAIT_HI: begin
          cmd_arg_o[31:16] <= rd_dat;
          cmd_set_o        <= (dir_o == DIR_TX) ? CMD_TX_SET : CMD_RX_SET;
          state            <= S_ISSUE;
        end
        S_ISSUE: begin
          // The first ISSUE cycle raises write_req_o; an ack only counts once it is up.
          if (write_req_o && we_ack_i) begin
            write_req_o <= 1'b0;
            if (cmd_done_i) begin
              bd_done_o <= ~cmd_err_i;
              bd_err_o  <= cmd_err_i;
              state     <= S_IDLE;
            end else begin
              state <= S_WAIT_DONE;
            end
          end else if (wd_expire) begin
            write_req_o <= 1'b0;
            bd_err_o    <= 1'b1;
            state       <= S_IDLE;
          end else begin
            write_req_o <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          // A real completion wins over a simultaneous watchdog expiry.
          if (cmd_done_i) begin
            bd_done_o <= ~cmd_err_i;
            bd_err_o  <= cmd_err_i;
            state     <= S_IDLE;
          end else if (wd_expire) begin
            bd_err_o <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_scheduler.sv
// Directed bench for sd_cmd_scheduler; checks the timeout case for
// whichever build (SD_SCHED_TIMEOUT_EN on or off) is compiled.
module tb_sd_cmd_scheduler;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        sched_en_i = 1'b0;
  logic        tx_bd_empty_i = 1'b1;
  logic        rx_bd_empty_i = 1'b1;
  logic        re_tx_bd_o, re_rx_bd_o;
  logic [15:0] tx_bd_dat_i = 16'h0;
  logic [15:0] rx_bd_dat_i = 16'h0;
  logic        write_req_o;
  logic [15:0] cmd_set_o;
  logic [31:0] cmd_arg_o;
  logic        we_ack_i = 1'b0;
  logic        cmd_done_i = 1'b0;
  logic        cmd_err_i = 1'b0;
  logic        busy_o, dir_o, bd_done_o, bd_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Queue models: each strobe returns the next stored word on the following cycle.
  logic [15:0] tx_mem [0:63];
  logic [15:0] rx_mem [0:63];
  logic [5:0]  tx_ptr = '0;
  logic [5:0]  rx_ptr = '0;
  int tx_re_cnt = 0, rx_re_cnt = 0, done_cnt = 0, err_cnt = 0;

  sd_cmd_scheduler #(
    .CMD_TX_SET (16'h181A),
    .CMD_RX_SET (16'h111A),
    .TIMEOUT    (16'd20)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .sched_en_i    (sched_en_i),
    .tx_bd_empty_i (tx_bd_empty_i),
    .rx_bd_empty_i (rx_bd_empty_i),
    .re_tx_bd_o    (re_tx_bd_o),
    .re_rx_bd_o    (re_rx_bd_o),
    .tx_bd_dat_i   (tx_bd_dat_i),
    .rx_bd_dat_i   (rx_bd_dat_i),
    .write_req_o   (write_req_o),
    .cmd_set_o     (cmd_set_o),
    .cmd_arg_o     (cmd_arg_o),
    .we_ack_i      (we_ack_i),
    .cmd_done_i    (cmd_done_i),
    .cmd_err_i     (cmd_err_i),
    .busy_o        (busy_o),
    .dir_o         (dir_o),
    .bd_done_o     (bd_done_o),
    .bd_err_o      (bd_err_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) begin
    if (re_tx_bd_o) begin
      tx_bd_dat_i <= tx_mem[tx_ptr];
      tx_ptr      <= tx_ptr + 6'd1;
      tx_re_cnt   <= tx_re_cnt + 1;
    end
    if (re_rx_bd_o) begin
      rx_bd_dat_i <= rx_mem[rx_ptr];
      rx_ptr      <= rx_ptr + 6'd1;
      rx_re_cnt   <= rx_re_cnt + 1;
    end
    if (bd_done_o) done_cnt <= done_cnt + 1;
    if (bd_err_o)  err_cnt  <= err_cnt + 1;
  end

  task automatic tick;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
  endtask

  // Wait (bounded) for a grant; returns cycles taken, 99 on expiry.
  task automatic wait_busy(output int n);
    n = 0;
    while (!busy_o && n < 99) begin tick(); n++; end
  endtask

  // Wait (bounded) for write_req_o; returns cycles taken, 99 on expiry.
  task automatic wait_wreq(output int n);
    n = 0;
    while (!write_req_o && n < 99) begin tick(); n++; end
  endtask

  task automatic pulse_reset;
    wb_rst_i = 1'b1; tick(); wb_rst_i = 1'b0; tick();
  endtask

  task automatic test_reset;
    wb_rst_i = 1'b1;
    tick();
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_checks++; if (dir_o !== 1'b0) begin n_fail++; $display("FAIL reset_dir got=%b exp=0", dir_o); end
    n_checks++; if (write_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_wreq got=%b exp=0", write_req_o); end
    n_checks++; if ({re_tx_bd_o, re_rx_bd_o, bd_done_o, bd_err_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_pulses got=%b exp=0000", {re_tx_bd_o, re_rx_bd_o, bd_done_o, bd_err_o}); end
    n_checks++; if (cmd_set_o !== 16'h0) begin n_fail++; $display("FAIL reset_set got=%h exp=0000", cmd_set_o); end
    n_checks++; if (cmd_arg_o !== 32'h0) begin n_fail++; $display("FAIL reset_arg got=%h exp=00000000", cmd_arg_o); end
    wb_rst_i = 1'b0;
    tick();
  endtask

  task automatic test_tx_only;
    int n, d0, t0, r0;
    tx_mem[tx_ptr] = 16'h1234; tx_mem[tx_ptr + 6'd1] = 16'hABCD;
    d0 = done_cnt; t0 = tx_re_cnt; r0 = rx_re_cnt;
    tx_bd_empty_i = 1'b0; rx_bd_empty_i = 1'b1; sched_en_i = 1'b1;
    wait_busy(n);
    sched_en_i = 1'b0; tx_bd_empty_i = 1'b1;
    n_checks++; if (dir_o !== 1'b1) begin n_fail++; $display("FAIL txo_dir got=%b exp=1", dir_o); end
    wait_wreq(n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL txo_latency got=%0d exp=5", n); end
    n_checks++; if (cmd_arg_o !== 32'hABCD1234) begin n_fail++; $display("FAIL txo_arg got=%h exp=abcd1234", cmd_arg_o); end
    n_checks++; if (cmd_set_o !== 16'h181A) begin n_fail++; $display("FAIL txo_set got=%h exp=181a", cmd_set_o); end
    n_checks++; if ((tx_re_cnt - t0) !== 2 || (rx_re_cnt - r0) !== 0) begin
      n_fail++; $display("FAIL txo_strobes got tx=%0d rx=%0d exp tx=2 rx=0", tx_re_cnt - t0, rx_re_cnt - r0); end
    we_ack_i = 1'b1; tick(); we_ack_i = 1'b0;
    n_checks++; if (write_req_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL txo_after_ack got wreq=%b busy=%b exp wreq=0 busy=1", write_req_o, busy_o); end
    tick(); tick();
    cmd_done_i = 1'b1; tick(); cmd_done_i = 1'b0;
    n_checks++; if (bd_done_o !== 1'b1 || bd_err_o !== 1'b0) begin
      n_fail++; $display("FAIL txo_result got done=%b err=%b exp done=1 err=0", bd_done_o, bd_err_o); end
    tick();
    n_checks++; if (bd_done_o !== 1'b0 || (done_cnt - d0) !== 1 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL txo_one_pulse got done=%b cnt=%0d busy=%b exp 0/1/0", bd_done_o, done_cnt - d0, busy_o); end
  endtask

  task automatic test_round_robin;
    int n;
    logic        exp_dir;
    logic [31:0] exp_arg;
    logic [15:0] exp_set;
    pulse_reset();
    tx_mem[tx_ptr] = 16'h1000; tx_mem[tx_ptr + 6'd1] = 16'h2000;
    tx_mem[tx_ptr + 6'd2] = 16'h1002; tx_mem[tx_ptr + 6'd3] = 16'h2002;
    rx_mem[rx_ptr] = 16'h3001; rx_mem[rx_ptr + 6'd1] = 16'h4001;
    rx_mem[rx_ptr + 6'd2] = 16'h3003; rx_mem[rx_ptr + 6'd3] = 16'h4003;
    tx_bd_empty_i = 1'b0; rx_bd_empty_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_dir = (k % 2 == 0);
      exp_set = exp_dir ? 16'h181A : 16'h111A;
      case (k)
        0: exp_arg = 32'h2000_1000;
        1: exp_arg = 32'h4001_3001;
        2: exp_arg = 32'h2002_1002;
        default: exp_arg = 32'h4003_3003;
      endcase
      sched_en_i = 1'b1;
      wait_busy(n);
      sched_en_i = 1'b0;
      n_checks++; if (dir_o !== exp_dir) begin n_fail++; $display("FAIL rr_dir[%0d] got=%b exp=%b", k, dir_o, exp_dir); end
      wait_wreq(n);
      n_checks++; if (cmd_set_o !== exp_set) begin n_fail++; $display("FAIL rr_set[%0d] got=%h exp=%h", k, cmd_set_o, exp_set); end
      n_checks++; if (cmd_arg_o !== exp_arg) begin n_fail++; $display("FAIL rr_arg[%0d] got=%h exp=%h", k, cmd_arg_o, exp_arg); end
      we_ack_i = 1'b1; tick(); we_ack_i = 1'b0;
      cmd_done_i = 1'b1; tick(); cmd_done_i = 1'b0;
      tick();
    end
    tx_bd_empty_i = 1'b1; rx_bd_empty_i = 1'b1;
  endtask

  task automatic test_error;
    int n, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    tx_mem[tx_ptr] = 16'h5555; tx_mem[tx_ptr + 6'd1] = 16'h6666;
    tx_mem[tx_ptr + 6'd2] = 16'h7777; tx_mem[tx_ptr + 6'd3] = 16'h8888;
    tx_bd_empty_i = 1'b0; sched_en_i = 1'b1;
    wait_busy(n);
    sched_en_i = 1'b0;
    wait_wreq(n);
    we_ack_i = 1'b1; tick(); we_ack_i = 1'b0;
    cmd_done_i = 1'b1; cmd_err_i = 1'b1; tick(); cmd_done_i = 1'b0; cmd_err_i = 1'b0;
    n_checks++; if (bd_err_o !== 1'b1 || bd_done_o !== 1'b0) begin
      n_fail++; $display("FAIL err_result got err=%b done=%b exp err=1 done=0", bd_err_o, bd_done_o); end
    tick();
    n_checks++; if (bd_err_o !== 1'b0 || (err_cnt - e0) !== 1 || (done_cnt - d0) !== 0) begin
      n_fail++; $display("FAIL err_one_pulse got err=%b errs=%0d dones=%0d exp 0/1/0", bd_err_o, err_cnt - e0, done_cnt - d0); end
    sched_en_i = 1'b1;
    wait_busy(n);
    sched_en_i = 1'b0; tx_bd_empty_i = 1'b1;
    n_checks++; if (n > 2) begin n_fail++; $display("FAIL err_next_grant got cycles=%0d exp<=2", n); end
    wait_wreq(n);
    n_checks++; if (cmd_arg_o !== 32'h8888_7777) begin n_fail++; $display("FAIL err_next_arg got=%h exp=88887777", cmd_arg_o); end
    we_ack_i = 1'b1; tick(); we_ack_i = 1'b0;
    cmd_done_i = 1'b1; tick(); cmd_done_i = 1'b0;
    n_checks++; if (bd_done_o !== 1'b1) begin n_fail++; $display("FAIL err_next_done got=%b exp=1", bd_done_o); end
    tick();
  endtask

  task automatic test_ack_done_same;
    int n, d0;
    d0 = done_cnt;
    tx_mem[tx_ptr] = 16'h0F0F; tx_mem[tx_ptr + 6'd1] = 16'hF0F0;
    tx_bd_empty_i = 1'b0; sched_en_i = 1'b1;
    wait_busy(n);
    sched_en_i = 1'b0; tx_bd_empty_i = 1'b1;
    wait_wreq(n);
    we_ack_i = 1'b1; cmd_done_i = 1'b1; tick(); we_ack_i = 1'b0; cmd_done_i = 1'b0;
    n_checks++; if (bd_done_o !== 1'b1 || busy_o !== 1'b0 || write_req_o !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle got done=%b busy=%b wreq=%b exp 1/0/0", bd_done_o, busy_o, write_req_o); end
    tick(); tick();
    n_checks++; if ((done_cnt - d0) !== 1) begin n_fail++; $display("FAIL same_cycle_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    int n, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    tx_mem[tx_ptr] = 16'hAAAA; tx_mem[tx_ptr + 6'd1] = 16'hBBBB;
    tx_bd_empty_i = 1'b0; sched_en_i = 1'b1;
    wait_busy(n);
    sched_en_i = 1'b0; tx_bd_empty_i = 1'b1;
    wait_wreq(n);
    we_ack_i = 1'b1; tick(); we_ack_i = 1'b0;
    tick();
    wb_rst_i = 1'b1; cmd_done_i = 1'b1;
    tick();
    n_checks++; if ({busy_o, dir_o, write_req_o, re_tx_bd_o, re_rx_bd_o, bd_done_o, bd_err_o} !== 7'b0 ||
                    cmd_set_o !== 16'h0 || cmd_arg_o !== 32'h0) begin
      n_fail++; $display("FAIL midrst_outputs got flags=%b set=%h arg=%h exp all 0",
        {busy_o, dir_o, write_req_o, re_tx_bd_o, re_rx_bd_o, bd_done_o, bd_err_o}, cmd_set_o, cmd_arg_o); end
    wb_rst_i = 1'b0;
    tick();
    cmd_done_i = 1'b0;
    tick();
    n_checks++; if ((done_cnt - d0) !== 0 || (err_cnt - e0) !== 0) begin
      n_fail++; $display("FAIL midrst_no_result got dones=%0d errs=%0d exp 0/0", done_cnt - d0, err_cnt - e0); end
    tx_mem[tx_ptr] = 16'hC001; tx_mem[tx_ptr + 6'd1] = 16'hC002;
    rx_mem[rx_ptr] = 16'hD001; rx_mem[rx_ptr + 6'd1] = 16'hD002;
    tx_bd_empty_i = 1'b0; rx_bd_empty_i = 1'b0; sched_en_i = 1'b1;
    wait_busy(n);
    sched_en_i = 1'b0; tx_bd_empty_i = 1'b1; rx_bd_empty_i = 1'b1;
    n_checks++; if (dir_o !== 1'b1) begin n_fail++; $display("FAIL midrst_tie got dir=%b exp=1", dir_o); end
    wait_wreq(n);
    we_ack_i = 1'b1; cmd_done_i = 1'b1; tick(); we_ack_i = 1'b0; cmd_done_i = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    int n;
    tx_mem[tx_ptr] = 16'h1111; tx_mem[tx_ptr + 6'd1] = 16'h2222;
    tx_bd_empty_i = 1'b0; sched_en_i = 1'b1;
    wait_busy(n);
    sched_en_i = 1'b0; tx_bd_empty_i = 1'b1;
    wait_wreq(n);
`ifdef SD_SCHED_TIMEOUT_EN
    // ISSUE was entered one cycle before write_req_o rose; expect the drop 19 cycles later.
    n = 0;
    while (write_req_o && n < 99) begin tick(); n++; end
    n_checks++; if (n !== 19) begin n_fail++; $display("FAIL to_cycles got=%0d exp=19", n); end
    n_checks++; if (bd_err_o !== 1'b1 || bd_done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL to_result got err=%b done=%b busy=%b exp 1/0/0", bd_err_o, bd_done_o, busy_o); end
`else
    for (int i = 0; i < 1000; i++) tick();
    n_checks++; if (write_req_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL no_to_hold got wreq=%b busy=%b exp 1/1", write_req_o, busy_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_tx_only();
    test_round_robin();
    test_error();
    test_ack_done_same();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_cmd_scheduler.md
SD_CMD_SCHEDULER -- requirements
Module: sd_cmd_scheduler

Interface
REQ-001 Parameter CMD_TX_SET, default 16'h181A, is the command setting issued for a TX descriptor (CMD24, 48-bit response, CRC and index check).
REQ-002 Parameter CMD_RX_SET, default 16'h111A, is the command setting issued for an RX descriptor (CMD17).
REQ-003 Parameter TIMEOUT, default 16'hFFFF, is the watchdog limit in wb_clk_i cycles.
REQ-004 wb_clk_i  in  1  clock; all logic is on the rising edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 sched_en_i  in  1  enables new grants.
REQ-007 tx_bd_empty_i / rx_bd_empty_i  in  1 each  the TX / RX descriptor queue is empty.
REQ-008 re_tx_bd_o / re_rx_bd_o  out  1 each  one-cycle read strobe; each strobe pops one 16-bit word.
REQ-009 tx_bd_dat_i / rx_bd_dat_i  in  16 each  descriptor word, valid on the cycle after the strobe.
REQ-010 write_req_o  out  1  command issue request.
REQ-011 cmd_set_o  out  16  command setting.
REQ-012 cmd_arg_o  out  32  command argument.
REQ-013 we_ack_i  in  1  one-cycle pulse: command accepted.
REQ-014 cmd_done_i / cmd_err_i  in  1 each  completion pulse; cmd_err_i is qualified by cmd_done_i.
REQ-015 busy_o  out  1  asserted in every state except IDLE.
REQ-016 dir_o  out  1  active direction (1 = TX), held for the whole descriptor.
REQ-017 bd_done_o / bd_err_o  out  1 each  one-cycle result pulse per descriptor.

Function
REQ-018 The block SHALL use states IDLE, RD_LO, WAIT_LO, RD_HI, WAIT_HI, ISSUE, WAIT_DONE.
REQ-019 In IDLE with sched_en_i=1 and at least one queue non-empty, the block SHALL grant one queue per the arbitration rules, latch dir_o and enter RD_LO.
- Only one queue non-empty: that queue is granted.
- Both non-empty: round-robin, granting opposite to the last granted direction.
- After reset, TX wins the first tie.
REQ-020 RD_LO and RD_HI SHALL each pulse the granted re_*_bd_o for exactly one cycle.
REQ-021 WAIT_LO SHALL capture the data word into cmd_arg_o[15:0]; WAIT_HI SHALL capture it into cmd_arg_o[31:16].
REQ-022 On entry to ISSUE, cmd_set_o SHALL equal CMD_TX_SET or CMD_RX_SET according to dir_o.
REQ-023 In ISSUE, write_req_o SHALL be held high until the cycle we_ack_i=1, then drop on the next edge; the state then moves to WAIT_DONE.
REQ-024 Latency from the grant to the first write_req_o high SHALL be exactly 5 cycles.
REQ-025 In WAIT_DONE, cmd_done_i SHALL cause a pulse on bd_done_o (cmd_err_i=0) or bd_err_o (cmd_err_i=1), then return to IDLE.
REQ-026 If we_ack_i and cmd_done_i are high in the same ISSUE cycle, the block SHALL complete directly to IDLE with the matching result pulse.
REQ-027 cmd_done_i and cmd_err_i SHALL be ignored in every state other than ISSUE and WAIT_DONE.
REQ-028 Deasserting sched_en_i mid-descriptor SHALL NOT abort it; it only blocks the next grant.
REQ-029 A queue going empty after its grant SHALL be ignored; the words are read regardless, and the empty-read condition is the producer's responsibility.
REQ-030 cmd_set_o and cmd_arg_o SHALL hold their values until the next descriptor overwrites them.

Reset
REQ-031 On wb_rst_i, the block SHALL enter IDLE and force the following values:
- write_req_o, re_*_bd_o, bd_done_o, bd_err_o, busy_o and dir_o = 0;
- cmd_set_o = 0 and cmd_arg_o = 0;
- the round-robin pointer selects TX next;
- the watchdog count = 0.
REQ-032 A reset asserted mid-operation SHALL drop write_req_o immediately and SHALL NOT emit bd_done_o or bd_err_o.

Configuration
REQ-033 With SD_SCHED_TIMEOUT_EN defined, a 16-bit counter SHALL operate as follows:
- it clears on entry to ISSUE and counts every cycle in ISSUE and WAIT_DONE;
- on reaching TIMEOUT, the block drops write_req_o, pulses bd_err_o and returns to IDLE.
REQ-034 Without SD_SCHED_TIMEOUT_EN, the counter SHALL be absent and ISSUE and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-035 Shared package sd_sched_pkg SHALL hold:
- the state enum;
- the default command constants CMD17_SET and CMD24_SET;
- the DIR_TX and DIR_RX constants.
REQ-036 The two-way round-robin SHALL be a sub-module sd_rr_arb2 (req[1:0], advance, grant[1:0]); the rest stays in one module.

Verification
REQ-037 TX only: tx words 16'h1234 then 16'hABCD, immediate we_ack_i, cmd_done_i 3 cycles later -> cmd_arg_o=32'hABCD1234, cmd_set_o=16'h181A, write_req_o high 5 cycles after grant, one bd_done_o pulse.
REQ-038 Both queues non-empty for 4 descriptors -> dir_o sequence TX, RX, TX, RX; cmd_set_o alternates 16'h181A / 16'h111A.
REQ-039 cmd_done_i with cmd_err_i=1 -> bd_err_o one cycle, bd_done_o stays 0, next descriptor still granted.
REQ-040 TIMEOUT=16'd20, macro on, no we_ack_i -> write_req_o drops and bd_err_o pulses 20 cycles after entering ISSUE; macro off -> write_req_o is still high after 1000 cycles.
REQ-041 wb_rst_i pulsed during WAIT_DONE -> all outputs 0 on the next cycle and no result pulse; a subsequent tie grants TX.
REQ-042 we_ack_i and cmd_done_i in the same cycle -> exactly one bd_done_o and a return to IDLE, with no stall in WAIT_DONE.
